// File: rtl/fb_stream_loader.sv
// fb_stream_loader: byte stream -> 64x64 3-bit framebuffer writer.
// Locks onto a two-byte header, then unpacks two pixels per byte
// (b[6:4] even pixel, b[2:0] odd pixel) and writes them in raster order.
module fb_stream_loader #(
  parameter logic [7:0]  SYNC0   = 8'hA5,
  parameter logic [7:0]  SYNC1   = 8'h5A,
  parameter int unsigned TIMEOUT = 24'd1_200_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        fb_we,
  output logic [11:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        busy,
  output logic        frame_done,
  output logic        err_timeout
);

  typedef enum logic [1:0] {HUNT, SYNC2, LOAD, WR_LO} state_t;

  // Last idle count in LOAD before the frame is abandoned.
  localparam logic [23:0] TMAX = 24'(TIMEOUT - 1);

  state_t      state_q;
  logic [10:0] ptr_q;     // byte index k within the frame
  logic [2:0]  lo_q;      // odd pixel held for the WR_LO cycle
  logic [23:0] tcnt_q;    // idle cycles in LOAD since last accept
  logic        fb_we_q, busy_q, done_q, err_q;
  logic [11:0] addr_q;
  logic [2:0]  data_q;
  logic        acc;

  // Ready is decoded from state so a byte can land the cycle LOAD is entered.
  assign rx_ready = resetn && (state_q != WR_LO);
  assign acc      = rx_valid && rx_ready;

  assign fb_we       = fb_we_q;
  assign fb_addr     = addr_q;
  assign fb_data     = data_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign err_timeout = err_q;

  // Header lock, pixel unpacking, write port and stall timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= HUNT;
      ptr_q   <= '0;
      lo_q    <= '0;
      tcnt_q  <= '0;
      fb_we_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fb_we_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        HUNT: begin
          if (acc && rx_data == SYNC0) state_q <= SYNC2;
        end
        SYNC2: begin
          if (acc) begin
            if (rx_data == SYNC1) begin
              state_q <= LOAD;
              ptr_q   <= '0;
              tcnt_q  <= '0;
              busy_q  <= 1'b1;
            end else if (rx_data != SYNC0) begin
              state_q <= HUNT;
            end
          end
        end
        LOAD: begin
          if (acc) begin
            state_q <= WR_LO;
            fb_we_q <= 1'b1;
            addr_q  <= {ptr_q, 1'b0};
            data_q  <= rx_data[6:4];
            lo_q    <= rx_data[2:0];
            tcnt_q  <= '0;
          end else if (tcnt_q == TMAX) begin
            // Stream stalled: drop the partial frame, keep what was written.
            state_q <= HUNT;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            tcnt_q  <= '0;
          end else begin
            tcnt_q  <= tcnt_q + 24'd1;
          end
        end
        WR_LO: begin
          fb_we_q <= 1'b1;
          addr_q  <= {ptr_q, 1'b1};
          data_q  <= lo_q;
          if (&ptr_q) begin
            state_q <= HUNT;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            state_q <= LOAD;
            ptr_q   <= ptr_q + 11'd1;
            tcnt_q  <= '0;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

endmodule

// File: doc/fb_stream_loader.md
# fb_stream_loader

Upstream write-side stage for the 64x64 3-bit RGB framebuffer. Consumes a byte stream (decoded UART bytes) with valid/ready, locks onto a two-byte sync header, unpacks two pixels per byte, and drives the framebuffer write port (we/addr/data) in raster order. Pulses `frame_done` after pixel 4095 is written; aborts and flags an error if the stream stalls mid-frame.

## Interface
- `SYNC0`, 8'hA5, first header byte
- `SYNC1`, 8'h5A, second header byte
- `TIMEOUT`, 24'd1_200_000, max idle cycles between accepted bytes while loading (100 ms at 12 MHz); must be ≥ 2
- `clk`  in  1  system clock; all logic on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `rx_data`  in  8  stream byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader can accept; byte transfers on an edge where `rx_valid && rx_ready`
- `fb_we`  out  1  framebuffer write enable
- `fb_addr`  out  12  pixel address, y*64+x
- `fb_data`  out  3  pixel RGB
- `busy`  out  1  high in LOAD or WR_LO
- `frame_done`  out  1  one-cycle pulse, full frame written
- `err_timeout`  out  1  one-cycle pulse, frame aborted on timeout

## Operation
- States: HUNT, SYNC2, LOAD, WR_LO. Reset → HUNT.
- `rx_ready` = state ∈ {HUNT, SYNC2, LOAD}; forced 0 while `resetn` low.
- HUNT: accepted byte == SYNC0 → SYNC2; any other byte discarded, stay.
- SYNC2: byte == SYNC1 → LOAD, pixel pointer `ptr` (11-bit byte index k) cleared, timeout counter cleared; byte == SYNC0 → stay SYNC2; other → HUNT.
- LOAD: every byte is pixel data (SYNC values not special). Byte b accepted → WR_LO; writes pixel 2k = b[6:4], latches b[2:0] for pixel 2k+1. b[7], b[3] ignored.
- WR_LO: writes pixel 2k+1; if k == 2047 → HUNT with `frame_done`, else k+1, → LOAD.
- Timeout: counter increments each cycle in LOAD with no accept, clears on accept. Reaching TIMEOUT-1 with no accept → HUNT, `err_timeout` pulse, `ptr` cleared. Pixels already written stay in framebuffer. Not active in HUNT/SYNC2/WR_LO.
- `fb_addr` = {k, 0} for high pixel, {k, 1} for low pixel; 12-bit, no wrap beyond 4095.
- Reset mid-frame: immediate return to HUNT, all outputs 0, partial frame abandoned; next frame needs a new header.

## Timing
- All outputs registered except `rx_ready` (decoded from state register).
- Reset values: `fb_we`=0, `fb_addr`=0, `fb_data`=0, `busy`=0, `frame_done`=0, `err_timeout`=0, `rx_ready`=0 during reset, 1 from first cycle after release.
- Byte accepted at edge E (LOAD): after E `fb_we`=1, addr=2k, data=hi, `rx_ready`=0. After E+1 `fb_we`=1, addr=2k+1, data=lo, `rx_ready`=1. Next byte can be accepted at E+2.
- Max throughput: one byte per 2 cycles, `fb_we` continuously high; full frame ≥ 4096 cycles after header.
- `fb_we` low in every cycle not covered above; `fb_addr`/`fb_data` hold last values when `fb_we`=0.
- `frame_done` high in the same cycle as the write of addr 4095 (after E+1 of the 2048th byte).
- `err_timeout` high for exactly one cycle, the cycle state returns to HUNT; `busy` low that same cycle.
- Framebuffer consumes write on the rising edge where `fb_we`=1; no back-pressure from framebuffer.

## Test plan
- Reset released, stream A5 5A then 2048 bytes 0x70 back-to-back → 4096 writes, addrs 0..4095 consecutive, even pixels data 7, odd 0; `frame_done` one pulse coincident with addr 4095; `busy` then 0.
- Header variants: 12 A5 A5 5A then byte 0x35 → first write addr 0 data 3, addr 1 data 5; stray 12 and extra A5 produce no writes.
- Header A5 33 5A then data → no writes (returns to HUNT on 33, 5A discarded in HUNT).
- `rx_valid` gaps of random 0-20 cycles within a frame, TIMEOUT=16 → byte after 15 idle cycles accepted normally; 16 idle cycles → `err_timeout` pulse, `busy` 0, following data bytes cause no writes until new header.
- `resetn` pulsed low after 100 data bytes → outputs 0 immediately, `rx_ready` 0 during reset; new header + 2048 bytes → writes restart at addr 0, single `frame_done`.
- Data bytes equal to A5/5A inside frame → written as pixels (A5 → 2, 5; 5A → 5, 2), no resync.
